// File: rtl/fp_minmax_reduce.sv
// Streaming min/max reduction over sign-magnitude floating-point vectors.
// Holds a running extreme, a sticky NaN flag and a saturating count; presents one result per vector.
module fp_minmax_reduce #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_op,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIGN_W-1:0] in_sign,
  input  logic [EXPO_W-1:0] in_expo,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIGN_W-1:0] out_sign,
  output logic [EXPO_W-1:0] out_expo,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_nan,
  output logic              out_mant_max,
  output logic [CNT_W-1:0]  out_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a clk edge where valid and ready are both high;
  // in_ready is registered (never a function of out_ready) and out_* hold while out_valid waits.

  localparam int MAG_W = EXPO_W + MANT_W;
  localparam int KEY_W = MAG_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [MANT_W-1:0] QNAN_MANT = MANT_W'(1) << (MANT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_rdy;
  logic                r_op;
  logic [SIGN_W-1:0]   r_acc_sign;
  logic [EXPO_W-1:0]   r_acc_expo;
  logic [MANT_W-1:0]   r_acc_mant;
  logic                r_nan;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_out_valid;
  logic [SIGN_W-1:0]   r_out_sign;
  logic [EXPO_W-1:0]   r_out_expo;
  logic [MANT_W-1:0]   r_out_mant;
  logic                r_out_nan;
  logic                r_out_mant_max;
  logic [CNT_W-1:0]    r_out_cnt;

  logic                w_accept;
  logic                w_first;
  logic                w_op;
  logic                w_in_nan;
  logic [KEY_W-1:0]    w_new_key;
  logic [KEY_W-1:0]    w_acc_key;
  logic                w_take;
  logic [SIGN_W-1:0]   w_nxt_sign;
  logic [EXPO_W-1:0]   w_nxt_expo;
  logic [MANT_W-1:0]   w_nxt_mant;
  logic                w_nxt_nan;
  logic [CNT_W-1:0]    w_nxt_cnt;
  logic [SIGN_W-1:0]   w_res_sign;
  logic [EXPO_W-1:0]   w_res_expo;
  logic [MANT_W-1:0]   w_res_mant;

  // Maps sign-magnitude onto an unsigned total order: negatives inverted and below all positives.
  function automatic logic [KEY_W-1:0] order_key(input logic s, input logic [MAG_W-1:0] mag);
    return s ? {1'b0, ~mag} : {1'b1, mag};
  endfunction

  always_comb begin
    w_accept   = in_valid & r_rdy;
    w_first    = (r_state == S_IDLE);
    w_op       = w_first ? cfg_op : r_op;
    w_in_nan   = (&in_expo) & (|in_mant);
    w_new_key  = order_key(in_sign[0], {in_expo, in_mant});
    w_acc_key  = order_key(r_acc_sign[0], {r_acc_expo, r_acc_mant});
    w_take     = w_first | (w_op ? (w_new_key < w_acc_key) : (w_new_key > w_acc_key));
    w_nxt_sign = w_take ? in_sign : r_acc_sign;
    w_nxt_expo = w_take ? in_expo : r_acc_expo;
    w_nxt_mant = w_take ? in_mant : r_acc_mant;
    w_nxt_nan  = (~w_first & r_nan) | w_in_nan;
    w_nxt_cnt  = w_first ? CNT_ONE : ((&r_cnt) ? r_cnt : r_cnt + CNT_ONE);
    w_res_sign = w_nxt_nan ? {SIGN_W{1'b0}} : w_nxt_sign;
    w_res_expo = w_nxt_nan ? {EXPO_W{1'b1}} : w_nxt_expo;
    w_res_mant = w_nxt_nan ? QNAN_MANT : w_nxt_mant;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rdy          <= 1'b0;
      r_op           <= 1'b0;
      r_acc_sign     <= '0;
      r_acc_expo     <= '0;
      r_acc_mant     <= '0;
      r_nan          <= 1'b0;
      r_cnt          <= '0;
      r_out_valid    <= 1'b0;
      r_out_sign     <= '0;
      r_out_expo     <= '0;
      r_out_mant     <= '0;
      r_out_nan      <= 1'b0;
      r_out_mant_max <= 1'b0;
      r_out_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          r_rdy <= 1'b1;
          if (w_accept) begin
            if (w_first) r_op <= cfg_op;
            r_acc_sign <= w_nxt_sign;
            r_acc_expo <= w_nxt_expo;
            r_acc_mant <= w_nxt_mant;
            r_nan      <= w_nxt_nan;
            r_cnt      <= w_nxt_cnt;
            if (in_last) begin
              r_state        <= S_DONE;
              r_rdy          <= 1'b0;
              r_out_valid    <= 1'b1;
              r_out_sign     <= w_res_sign;
              r_out_expo     <= w_res_expo;
              r_out_mant     <= w_res_mant;
              r_out_nan      <= w_nxt_nan;
              r_out_mant_max <= &w_res_mant;
              r_out_cnt      <= w_nxt_cnt;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_rdy       <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_rdy & rst_n;
  assign out_valid    = r_out_valid;
  assign out_sign     = r_out_sign;
  assign out_expo     = r_out_expo;
  assign out_mant     = r_out_mant;
  assign out_nan      = r_out_nan;
  assign out_mant_max = r_out_mant_max;
  assign out_cnt      = r_out_cnt;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Directed bench for fp_minmax_reduce: FP32 instance plus a CNT_W=2 instance for saturation.
module tb_fp_minmax_reduce;

  logic        clk;
  logic        rst_n;
  logic        cfg_op;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_sign;
  logic [7:0]  in_expo;
  logic [22:0] in_mant;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_sign;
  logic [7:0]  out_expo;
  logic [22:0] out_mant;
  logic        out_nan;
  logic        out_mant_max;
  logic [7:0]  out_cnt;
  logic [1:0]  dbg_state;

  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic        out_ready2;
  logic [0:0]  out_sign2;
  logic [7:0]  out_expo2;
  logic [22:0] out_mant2;
  logic        out_nan2;
  logic        out_mant_max2;
  logic [1:0]  out_cnt2;
  logic [1:0]  dbg_state2;

  int n_checks;
  int n_errors;
  logic [31:0] held_word;

  fp_minmax_reduce dut (
    .clk(clk), .rst_n(rst_n), .cfg_op(cfg_op), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_expo(in_expo), .in_mant(in_mant), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_expo(out_expo),
    .out_mant(out_mant), .out_nan(out_nan), .out_mant_max(out_mant_max), .out_cnt(out_cnt),
    .dbg_state(dbg_state)
  );

  fp_minmax_reduce #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_op(cfg_op), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_sign(in_sign), .in_expo(in_expo), .in_mant(in_mant), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_sign(out_sign2), .out_expo(out_expo2),
    .out_mant(out_mant2), .out_nan(out_nan2), .out_mant_max(out_mant_max2), .out_cnt(out_cnt2),
    .dbg_state(dbg_state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one element for exactly one edge on the main instance.
  task automatic send(input logic op, input logic [31:0] w, input logic last);
    cfg_op   = op;
    {in_sign, in_expo, in_mant} = w;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] w, input logic nan,
                              input logic mm, input logic [7:0] cnt);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_word"}, {out_sign, out_expo, out_mant}, w);
    chk({tag, "_nan"}, out_nan, nan);
    chk({tag, "_mmax"}, out_mant_max, mm);
    chk({tag, "_cnt"}, out_cnt, cnt);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, out_valid, 1'b0);
    chk({tag, "_idle_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; cfg_op = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    {in_sign, in_expo, in_mant} = 32'h0;
    out_ready = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_word", {out_sign, out_expo, out_mant}, 32'h0);
    chk("rst_nan", out_nan, 1'b0);
    chk("rst_cnt", out_cnt, 8'd0);
    chk("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    chk("rst_rel_ready_lo", in_ready, 1'b0);
    tick();
    chk("rst_rel_ready_hi", in_ready, 1'b1);

    // Max mode with an idle gap in ACC
    send(1'b0, 32'h3F800000, 1'b0);
    chk("v1_acc_state", dbg_state, 2'd1);
    tick(); tick();
    chk("v1_gap_state", dbg_state, 2'd1);
    chk("v1_gap_valid", out_valid, 1'b0);
    send(1'b0, 32'hC0000000, 1'b0);
    cfg_op = 1'b0; {in_sign, in_expo, in_mant} = 32'h40400000; in_last = 1'b1; in_valid = 1'b1;
    #3;
    chk("v1_pre_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check_result("v1", 32'h40400000, 1'b0, 1'b0, 8'd3);
    consume("v1");

    // Min mode: -0 below +0
    send(1'b1, 32'h00000000, 1'b0);
    send(1'b1, 32'h80000000, 1'b1);
    check_result("v2", 32'h80000000, 1'b0, 1'b0, 8'd2);
    consume("v2");

    // Single element, mantissa all ones
    send(1'b0, 32'h7F7FFFFF, 1'b1);
    check_result("v3", 32'h7F7FFFFF, 1'b0, 1'b1, 8'd1);
    consume("v3");

    // NaN is sticky and canonicalised
    send(1'b0, 32'h3F800000, 1'b0);
    send(1'b0, 32'h7F800001, 1'b0);
    send(1'b0, 32'h7F800000, 1'b1);
    check_result("v4", 32'h7FC00000, 1'b1, 1'b0, 8'd3);
    consume("v4");

    // cfg_op flipped mid-vector is ignored (min stays latched)
    send(1'b1, 32'h40000000, 1'b0);
    send(1'b0, 32'h40400000, 1'b0);
    send(1'b0, 32'h3F800000, 1'b1);
    check_result("v5", 32'h3F800000, 1'b0, 1'b0, 8'd3);
    consume("v5");

    // Max over negatives, and infinities ordered normally
    send(1'b0, 32'hC0400000, 1'b0);
    send(1'b0, 32'hBF800000, 1'b1);
    check_result("v6", 32'hBF800000, 1'b0, 1'b0, 8'd2);
    consume("v6");
    send(1'b1, 32'h7F800000, 1'b0);
    send(1'b1, 32'hFF800000, 1'b1);
    check_result("v7", 32'hFF800000, 1'b0, 1'b0, 8'd2);
    consume("v7");

    // Equal magnitudes keep the first; min of {+1,+1} still +1 with cnt 2
    send(1'b1, 32'h3F800000, 1'b0);
    send(1'b1, 32'h3F800000, 1'b1);
    check_result("v8", 32'h3F800000, 1'b0, 1'b0, 8'd2);
    consume("v8");

    // Backpressure in DONE with an element offered that must not be taken
    send(1'b0, 32'h41200000, 1'b1);
    held_word = {out_sign, out_expo, out_mant};
    chk("v9_word", held_word, 32'h41200000);
    cfg_op = 1'b0; {in_sign, in_expo, in_mant} = 32'h50000000; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("v9_hold_valid", out_valid, 1'b1);
      chk("v9_hold_ready", in_ready, 1'b0);
      chk("v9_hold_word", {out_sign, out_expo, out_mant}, 32'h41200000);
      chk("v9_hold_cnt", out_cnt, 8'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("v9_rel_state", dbg_state, 2'd0);
    chk("v9_rel_valid", out_valid, 1'b0);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check_result("v10", 32'h50000000, 1'b0, 1'b0, 8'd1);
    consume("v10");

    // Reset abandons a vector in ACC
    send(1'b0, 32'h7F000000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("v11_rst_ready", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    chk("v11_rst_valid", out_valid, 1'b0);
    chk("v11_rst_state", dbg_state, 2'd0);
    tick();
    chk("v11_post_valid", out_valid, 1'b0);
    send(1'b0, 32'h3F800000, 1'b1);
    check_result("v11", 32'h3F800000, 1'b0, 1'b0, 8'd1);

    // Reset while DONE drops the pending result
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("v12_rst_valid", out_valid, 1'b0);
    chk("v12_rst_word", {out_sign, out_expo, out_mant}, 32'h0);
    tick();

    // Saturating count on the CNT_W=2 instance
    cfg_op = 1'b0; in_valid2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {in_sign, in_expo, in_mant} = 32'h3F800000 + 32'(i);
      in_last = (i == 4);
      tick();
    end
    in_valid2 = 1'b0; in_last = 1'b0;
    chk("v13_valid", out_valid2, 1'b1);
    chk("v13_cnt", out_cnt2, 2'd3);
    chk("v13_word", {out_sign2, out_expo2, out_mant2}, 32'h3F800004);
    chk("v13_main_idle", out_valid, 1'b0);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    chk("v13_idle_valid", out_valid2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_minmax_reduce.md
FP_MINMAX_REDUCE -- requirements
Module: fp_minmax_reduce

Interface
REQ-001 Parameter SIGN_W, default 1, sign field width; the only supported value is 1.
REQ-002 Parameter EXPO_W, default 8, exponent field width.
REQ-003 Parameter MANT_W, default 23, mantissa field width.
REQ-004 Parameter CNT_W, default 8, element counter width.
REQ-005 Port list (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, reset; synchronous, active-low.
- cfg_op, in, 1, 0=max, 1=min; sampled with the first element of a vector.
- in_valid, in, 1, operand valid.
- in_ready, out, 1, operand accepted when in_valid and in_ready are both high.
- in_sign, in, SIGN_W, operand sign.
- in_expo, in, EXPO_W, operand exponent.
- in_mant, in, MANT_W, operand mantissa.
- in_last, in, 1, final element of the vector.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- out_sign, out, SIGN_W, result sign.
- out_expo, out, EXPO_W, result exponent.
- out_mant, out, MANT_W, result mantissa.
- out_nan, out, 1, at least one NaN operand was seen in the vector.
- out_mant_max, out, 1, result mantissa is all ones.
- out_cnt, out, CNT_W, accepted element count, saturating.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-007 In IDLE, in_ready=1 and out_valid=0; an accepted element loads the accumulator, latches cfg_op and sets cnt=1; the next state is DONE if in_last, else ACC.
REQ-008 In ACC, in_ready=1; an accepted element updates the accumulator and increments cnt; the next state is DONE if in_last.
REQ-009 In DONE, in_ready=0 and out_valid=1, with all out_* fields held stable; on out_ready the next state is IDLE.
REQ-010 out_valid SHALL rise on the cycle after the handshake of the last element (latency 1); a single-element vector is legal.
REQ-011 Ordering SHALL be total over sign-magnitude values: positive values are ordered by {expo,mant} ascending, negative values by {expo,mant} descending, and every negative value is below every positive value, so -0 < +0.
REQ-012 In max mode the accumulator SHALL be replaced when the new element is strictly greater; in min mode, when it is strictly smaller; on equality the accumulator is kept.
REQ-013 An element is NaN when expo is all ones and mant is nonzero; infinities (expo all ones, mant zero) are ordered normally.
REQ-014 Any NaN element SHALL set a sticky nan flag for the vector; when the flag is set, the result SHALL be the canonical NaN (sign 0, expo all ones, mant MSB 1, other mant bits 0), regardless of the accumulator.
REQ-015 out_mant_max SHALL equal (out_mant == all ones) on the presented result; it is 0 when out_nan=1 and MANT_W>1.
REQ-016 out_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 A cfg_op change in mid-vector SHALL be ignored; the latched value applies until the next IDLE load.
REQ-018 In ACC with in_valid=0, all state SHALL hold.
REQ-019 The block SHALL NOT accept an element while in DONE; there is no combinational path from out_ready to in_ready.

Reset
REQ-020 While rst_n=0 at a clk edge: state=IDLE; accumulator, nan flag and cnt cleared; out_valid=0; all out_* fields=0.
REQ-021 Reset asserted in ACC or DONE SHALL abandon the vector, with no result presented.
REQ-022 With rst_n=0, in_ready SHALL read 0; it returns to 1 the cycle after rst_n rises.

Verification (FP32 defaults)
REQ-023 Max mode, vector {0x3F800000, 0xC0000000, 0x40400000 last} -> one cycle later out_valid=1, result 0x40400000, out_cnt=3, out_nan=0.
REQ-024 Min mode, vector {0x00000000, 0x80000000 last} -> result 0x80000000; single element 0x7F7FFFFF with last in max mode -> result 0x7F7FFFFF, out_mant_max=1, out_cnt=1.
REQ-025 Max mode, vector {0x3F800000, 0x7F800001, 0x7F800000 last} -> result 0x7FC00000, out_nan=1, out_mant_max=0.
REQ-026 Hold out_ready=0 for 5 cycles in DONE -> out_* stable and in_ready=0 throughout; on out_ready=1, IDLE on the next cycle, and a back-to-back new vector is accepted.
REQ-027 CNT_W=2, 5-element vector -> out_cnt=3; separately, rst_n=0 mid-vector -> no out_valid, and the next vector result is independent of the abandoned data.
